// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register.
// Four requesters; one owner at a time, bounded hold, one idle cycle between grants.
`timescale 1ns/1ps
module shared_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [3:0]         we,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [1:0]         owner,
    output logic               busy,
    output logic               timeout,
    output logic [WIDTH-1:0]   q
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] cnt;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       pick_valid;

    // Descending scan so the requester closest to ptr wins.
    always_comb begin
        pick       = 2'd0;
        pick_valid = 1'b0;
        idx        = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= 4'b0;
            owner   <= 2'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            q       <= '0;
            ptr     <= 2'd0;
            cnt     <= 8'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt   <= 4'b0001 << pick;
                        owner <= pick;
                        busy  <= 1'b1;
                        cnt   <= 8'd0;
                        ptr   <= pick + 2'd1;
                        state <= GRANT;
                    end else begin
                        gnt <= 4'b0;
                    end
                end
                GRANT: begin
                    if (req[owner] && we[owner])
                        q <= wdata[owner*WIDTH +: WIDTH];
                    if (!req[owner]) begin
                        gnt   <= 4'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == HOLD_LAST) begin
                        gnt     <= 4'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
